// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between instruction fetch and
//            load/store, with a response watchdog. Define ARB_ROUND_ROBIN_EN
//            for round-robin arbitration between the two ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int DATAWIDTH      = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  ARB_Clk_In,
    input  logic                  ARB_Reset_In,
    input  logic                  ARB_Ins_Re_In,
    input  logic [DATAWIDTH-1:0]  ARB_Ins_Addr_InBUS,
    output logic [DATAWIDTH-1:0]  ARB_Ins_Readdata_OutBUS,
    output logic                  ARB_Ins_Read_Valid_Out,
    input  logic                  ARB_Data_Re_In,
    input  logic                  ARB_Data_We_In,
    input  logic [DATAWIDTH-1:0]  ARB_Data_Addr_InBUS,
    input  logic [3:0]            ARB_Data_Byteenable_InBUS,
    input  logic [DATAWIDTH-1:0]  ARB_Data_Writedata_InBUS,
    output logic [DATAWIDTH-1:0]  ARB_Data_Readdata_OutBUS,
    output logic                  ARB_Data_Read_Valid_Out,
    output logic                  ARB_Data_Write_Ready_Out,
    output logic                  ARB_Mem_Re_Out,
    output logic                  ARB_Mem_We_Out,
    output logic [ADDR_WIDTH-1:0] ARB_Mem_Addr_OutBUS,
    output logic [3:0]            ARB_Mem_Byteenable_OutBUS,
    output logic [DATAWIDTH-1:0]  ARB_Mem_Writedata_OutBUS,
    input  logic [DATAWIDTH-1:0]  ARB_Mem_Readdata_InBUS,
    input  logic                  ARB_Mem_Read_Valid_In,
    input  logic                  ARB_Mem_Write_Ready_In,
    output logic                  ARB_Busy_Out,
    output logic                  ARB_Timeout_Out
);

    localparam int                    c_WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_WD_W-1:0]     c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATAWIDTH-1:0]  c_POISON  = DATAWIDTH'(32'hDEADBEEF);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INS_RD = 3'd1,
        S_DAT_RD = 3'd2,
        S_DAT_WR = 3'd3,
        S_RESP   = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic                    mem_re_q, mem_re_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]              mem_be_q, mem_be_d;
    logic [DATAWIDTH-1:0]    mem_wd_q, mem_wd_d;
    logic [DATAWIDTH-1:0]    ins_rd_q, ins_rd_d;
    logic [DATAWIDTH-1:0]    dat_rd_q, dat_rd_d;
    logic                    ins_rv_q, ins_rv_d;
    logic                    dat_rv_q, dat_rv_d;
    logic                    dat_wr_q, dat_wr_d;
    logic                    busy_q, busy_d;
    logic                    timeout_q, timeout_d;
    logic [c_WD_W-1:0]       wd_q, wd_d;

    logic                    w_data_req;
    logic                    w_pick_data;
    logic                    w_done;

    assign w_data_req = ARB_Data_Re_In | ARB_Data_We_In;

`ifdef ARB_ROUND_ROBIN_EN
    // last_data_q = 1 when the data port won the most recent grant
    logic last_data_q, last_data_d;
    assign w_pick_data = w_data_req & (~ARB_Ins_Re_In | ~last_data_q);
`else
    assign w_pick_data = w_data_req;
`endif

    assign w_done = (state_q == S_DAT_WR) ? ARB_Mem_Write_Ready_In : ARB_Mem_Read_Valid_In;

    always_comb begin
        state_d   = state_q;
        mem_re_d  = mem_re_q;
        mem_we_d  = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_be_d  = mem_be_q;
        mem_wd_d  = mem_wd_q;
        ins_rd_d  = ins_rd_q;
        dat_rd_d  = dat_rd_q;
        ins_rv_d  = 1'b0;
        dat_rv_d  = 1'b0;
        dat_wr_d  = 1'b0;
        timeout_d = timeout_q;
        wd_d      = wd_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_data_d = last_data_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                wd_d = '0;
                if (w_pick_data) begin
                    mem_addr_d = ARB_Data_Addr_InBUS[ADDR_WIDTH-1:0];
`ifdef ARB_ROUND_ROBIN_EN
                    last_data_d = 1'b1;
`endif
                    if (ARB_Data_We_In) begin
                        state_d  = S_DAT_WR;
                        mem_we_d = 1'b1;
                        mem_be_d = ARB_Data_Byteenable_InBUS;
                        mem_wd_d = ARB_Data_Writedata_InBUS;
                    end else begin
                        state_d  = S_DAT_RD;
                        mem_re_d = 1'b1;
                    end
                end else if (ARB_Ins_Re_In) begin
                    state_d    = S_INS_RD;
                    mem_re_d   = 1'b1;
                    mem_addr_d = ARB_Ins_Addr_InBUS[ADDR_WIDTH-1:0];
`ifdef ARB_ROUND_ROBIN_EN
                    last_data_d = 1'b0;
`endif
                end
            end
            S_INS_RD, S_DAT_RD, S_DAT_WR: begin
                // Completion is checked first so it beats a same-cycle timeout
                if (w_done || (wd_q == c_WD_LAST)) begin
                    state_d  = S_RESP;
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (!w_done) begin
                        timeout_d = 1'b1;
                    end
                    if (state_q == S_INS_RD) begin
                        ins_rv_d = 1'b1;
                        ins_rd_d = w_done ? ARB_Mem_Readdata_InBUS : c_POISON;
                    end else if (state_q == S_DAT_RD) begin
                        dat_rv_d = 1'b1;
                        dat_rd_d = w_done ? ARB_Mem_Readdata_InBUS : c_POISON;
                    end else begin
                        dat_wr_d = 1'b1;
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge ARB_Clk_In) begin
        if (ARB_Reset_In) begin
            state_q    <= S_IDLE;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_be_q   <= '0;
            mem_wd_q   <= '0;
            ins_rd_q   <= '0;
            dat_rd_q   <= '0;
            ins_rv_q   <= 1'b0;
            dat_rv_q   <= 1'b0;
            dat_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            wd_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_be_q   <= mem_be_d;
            mem_wd_q   <= mem_wd_d;
            ins_rd_q   <= ins_rd_d;
            dat_rd_q   <= dat_rd_d;
            ins_rv_q   <= ins_rv_d;
            dat_rv_q   <= dat_rv_d;
            dat_wr_q   <= dat_wr_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            wd_q       <= wd_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q <= last_data_d;
`endif
        end
    end

    generate
        if (ADDR_WIDTH < DATAWIDTH) begin : g_unused_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^{ARB_Ins_Addr_InBUS[DATAWIDTH-1:ADDR_WIDTH],
                                        ARB_Data_Addr_InBUS[DATAWIDTH-1:ADDR_WIDTH]};
        end
    endgenerate

    assign ARB_Ins_Readdata_OutBUS   = ins_rd_q;
    assign ARB_Ins_Read_Valid_Out    = ins_rv_q;
    assign ARB_Data_Readdata_OutBUS  = dat_rd_q;
    assign ARB_Data_Read_Valid_Out   = dat_rv_q;
    assign ARB_Data_Write_Ready_Out  = dat_wr_q;
    assign ARB_Mem_Re_Out            = mem_re_q;
    assign ARB_Mem_We_Out            = mem_we_q;
    assign ARB_Mem_Addr_OutBUS       = mem_addr_q;
    assign ARB_Mem_Byteenable_OutBUS = mem_be_q;
    assign ARB_Mem_Writedata_OutBUS  = mem_wd_q;
    assign ARB_Busy_Out              = busy_q;
    assign ARB_Timeout_Out           = timeout_q;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory (INS_MEM/DATAMEM-style Re/We/Read_Valid/Write_Ready interface) between the core's instruction-fetch port and its load/store port.
- Sits between CORE and the memory. Grants one transaction at a time, holds memory strobes until the memory completes, then returns a one-cycle response pulse to the granted requester.
- Includes a response watchdog so a hung memory cannot stall the core indefinitely.

Parameters:
- DATAWIDTH, 32: data/address bus width
- ADDR_WIDTH, 10: memory address bits forwarded, taken from the low bits of the requester address
- TIMEOUT_CYCLES, 64: maximum strobe cycles before a transaction is aborted; must be at least 2

Ports:
- ARB_Clk_In  in  1  clock
- ARB_Reset_In  in  1  reset, synchronous, active-high
- ARB_Ins_Re_In  in  1  instruction read request (level, held until response)
- ARB_Ins_Addr_InBUS  in  DATAWIDTH  fetch address
- ARB_Ins_Readdata_OutBUS  out  DATAWIDTH  fetched word
- ARB_Ins_Read_Valid_Out  out  1  one-cycle fetch response pulse
- ARB_Data_Re_In  in  1  load request (level)
- ARB_Data_We_In  in  1  store request (level)
- ARB_Data_Addr_InBUS  in  DATAWIDTH  load/store address
- ARB_Data_Byteenable_InBUS  in  4  store byte enables
- ARB_Data_Writedata_InBUS  in  DATAWIDTH  store data
- ARB_Data_Readdata_OutBUS  out  DATAWIDTH  load data
- ARB_Data_Read_Valid_Out  out  1  one-cycle load response pulse
- ARB_Data_Write_Ready_Out  out  1  one-cycle store-complete pulse
- ARB_Mem_Re_Out  out  1  memory read strobe
- ARB_Mem_We_Out  out  1  memory write strobe
- ARB_Mem_Addr_OutBUS  out  ADDR_WIDTH  memory address
- ARB_Mem_Byteenable_OutBUS  out  4  memory byte enables
- ARB_Mem_Writedata_OutBUS  out  DATAWIDTH  memory write data
- ARB_Mem_Readdata_InBUS  in  DATAWIDTH  memory read data
- ARB_Mem_Read_Valid_In  in  1  memory read complete
- ARB_Mem_Write_Ready_In  in  1  memory write complete
- ARB_Busy_Out  out  1  high in any state other than IDLE
- ARB_Timeout_Out  out  1  sticky watchdog flag, cleared only by reset

Behaviour:
- All outputs are registered. On reset: state=IDLE, all strobes, response pulses, Busy and Timeout = 0; address, data and readdata buses = 0; watchdog = 0; last-grant = INS.
- Reset asserted mid-transaction aborts it. Strobes are low from the cycle after the reset edge, and no response pulse is issued.
- FSM states: IDLE, INS_RD, DAT_RD, DAT_WR, RESP.
- IDLE arbitration (fixed priority, default): data over instruction.
  - Data We=1 -> DAT_WR. Store wins if Re and We are both high.
  - Else data Re=1 -> DAT_RD.
  - Else Ins Re=1 -> INS_RD.
- On the grant edge, latch address[ADDR_WIDTH-1:0], byteenable and writedata. Drive the matching strobe from the next cycle. Unused buses hold their last value.
- INS_RD/DAT_RD: Re held high until Mem_Read_Valid_In=1 in cycle M. Capture Mem_Readdata into the requester's readdata register. Drop Re and enter RESP at M+1, pulsing the requester's Read_Valid for exactly cycle M+1.
- DAT_WR: same flow on Mem_Write_Ready_In; Data_Write_Ready_Out pulses in cycle M+1.
- RESP -> IDLE unconditionally. Requests are ignored in RESP, which gives requesters one cycle to drop or change their request.
- Back-to-back transactions therefore have at least one IDLE cycle between a response pulse and the next strobe.
- The readdata output registers hold their value until the next completion on the same port.
- Memory valid/ready signals arriving outside a matching strobe state are ignored.
- Watchdog: counts cycles in INS_RD/DAT_RD/DAT_WR and resets on entry to each of them.
  - When the count reaches TIMEOUT_CYCLES without completion: drop the strobe, set Timeout, go to RESP and pulse the granted requester's response.
  - On a read timeout, readdata is forced to 32'hDEADBEEF.
  - If completion and timeout occur in the same cycle, completion wins and Timeout is not set.
- Requests that drop before grant are simply not served. Requests that drop after grant do not abort the transaction.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both ports request in IDLE, the port not granted last wins. Last-grant updates on every grant and resets to INS, so the first contested grant goes to data. Store-over-load priority within the data port is unchanged.
- Undefined: fixed data-over-instruction priority; the last-grant register is not built.

Test Plan:
- Ins Re=1, addr 0x0000_0010; memory Read_Valid 1 cycle after Re with data 0x00A00093 -> Mem_Addr=0x010; Ins_Read_Valid pulses exactly 1 cycle with readdata 0x00A00093; Busy low afterwards.
- Ins Re and Data We (addr 0x20, BE 4'b0011, data 0x1234ABCD) asserted in the same cycle, fixed priority -> store performed first with Mem_Byteenable=0011; fetch strobe starts 1 IDLE cycle after Write_Ready pulse.
- Same contention repeated 4 times with ARB_ROUND_ROBIN_EN -> grant order DATA, INS, DATA, INS.
- Data Re=1, memory never responds, TIMEOUT_CYCLES=64 -> Re drops after 64 strobe cycles; Data_Read_Valid pulses with 0xDEADBEEF; Timeout=1 and stays set until reset.
- Reset pulsed 1 cycle while in DAT_RD -> next cycle strobes=0, state IDLE, no Read_Valid pulse, Timeout=0.
- Data Re and We both high, addr 0x8 -> only Mem_We asserted; Data_Write_Ready pulses; Data_Read_Valid stays 0.
